// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART block family.
// Holds the TX arbiter state encoding and the header tag used when the
// UART_TX_ARB_HEADER_EN build option prefixes each grant with a tag byte.
package apb_uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HDR    = 2'd1,
    STREAM = 2'd2
  } uart_tx_arb_state_e;

  localparam logic [3:0] HDR_TAG = 4'hA;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin search: finds the first set request bit scanning upward
// from ptr_i with wrap-around. Purely combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the farthest offset down so the closest requester wins last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % N]) begin
        found_o = 1'b1;
        idx_o   = IW'((int'(ptr_i) + i) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing the UART TX FIFO write port
// among NUM_REQ byte-stream requesters. A grant lasts until the owner's
// last byte or MAX_BURST bytes, whichever comes first.
// Build option UART_TX_ARB_HEADER_EN: each grant starts with a header byte
// {HDR_TAG, grant index} before the requester's bytes.
module uart_tx_arbiter
  import apb_uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 enable_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_END = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

  uart_tx_arb_state_e state_q, state_d;
  logic [IW-1:0] grant_idx_q, grant_idx_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;

  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [7:0]         sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic [IW-1:0]      next_ptr;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign grant_oh  = NUM_REQ'(1) << grant_idx_q;
  assign sel_data  = req_data_i[{grant_idx_q, 3'b000} +: 8];
  assign sel_valid = req_valid_i[grant_idx_q];
  assign sel_last  = req_last_i[grant_idx_q];
  assign next_ptr  = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
  assign busy_o    = (state_q != IDLE);

`ifdef UART_TX_ARB_HEADER_EN
  logic [3:0] hdr_idx;
  assign hdr_idx = 4'(grant_idx_q);
`endif

  // Next-state and output decode; IDLE keeps every output at its reset value.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    req_ready_o = '0;
    out_data_o  = '0;
    out_valid_o = 1'b0;
    grant_o     = '0;

    case (state_q)
      IDLE: begin
        if (enable_i && pick_found) begin
          grant_idx_d = pick_idx;
          beat_cnt_d  = '0;
`ifdef UART_TX_ARB_HEADER_EN
          state_d     = HDR;
`else
          state_d     = STREAM;
`endif
        end
      end

`ifdef UART_TX_ARB_HEADER_EN
      HDR: begin
        out_valid_o = 1'b1;
        out_data_o  = {HDR_TAG, hdr_idx};
        grant_o     = grant_oh;
        if (out_ready_i) begin
          state_d = STREAM;
        end
      end
`endif

      STREAM: begin
        out_data_o  = sel_data;
        out_valid_o = sel_valid;
        req_ready_o = grant_oh & {NUM_REQ{out_ready_i}};
        grant_o     = grant_oh;
        if (sel_valid && out_ready_i) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          // Packet end or burst truncation both hand the path onward.
          if (sel_last || (beat_cnt_q == BURST_END)) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any packet in flight.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Cycle-by-cycle vector bench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=4).
// Each record holds the inputs for one clock cycle and the outputs expected
// during that cycle; inputs change on the falling edge, outputs are checked
// shortly after. Accepted bytes are also collected and compared against the
// expected wire stream to catch loss or duplication.
module tb_uart_tx_arbiter;

  typedef struct {
    logic        arst;
    logic        en;
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [7:0]  od;
    logic [3:0]  gnt;
    logic        busy;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic [31:0] req_data_i = '0;
  logic [3:0]  req_valid_i = '0;
  logic [3:0]  req_last_i = '0;
  logic [3:0]  req_ready_o;
  logic [7:0]  out_data_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [3:0]  grant_o;
  logic        busy_o;

  vec_t       vecs[$];
  logic [7:0] seen[$];
  logic [7:0] want[$];
  int         n_vec = 0;
  int         n_bad = 0;

  uart_tx_arbiter #(
    .NUM_REQ   (4),
    .MAX_BURST (4)
  ) dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .enable_i    (enable_i),
    .req_data_i  (req_data_i),
    .req_valid_i (req_valid_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Cycle where the arbiter is expected idle: all outputs zero.
  task automatic idle(input logic arst, input logic en, input logic [3:0] vld,
                      input logic [3:0] lst, input logic [31:0] data, input logic ordy);
    vec_t v;
    v = '{arst, en, vld, lst, data, ordy, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    vecs.push_back(v);
  endtask

  // Cycle where a grant is active (busy high).
  task automatic act(input logic en, input logic [3:0] vld, input logic [3:0] lst,
                     input logic [31:0] data, input logic ordy, input logic [3:0] rdy,
                     input logic ov, input logic [7:0] od, input logic [3:0] gnt);
    vec_t v;
    v = '{1'b0, en, vld, lst, data, ordy, rdy, ov, od, gnt, 1'b1};
    vecs.push_back(v);
  endtask

  initial begin
    idle(1, 0, 4'b0000, 4'b0000, 32'h0, 0);

`ifdef UART_TX_ARB_HEADER_EN
    // req3 sends 0x55 as a one-byte packet: header 0xA3 precedes it.
    idle(0, 1, 4'b1000, 4'b1000, 32'h5500_0000, 1);
    act (1, 4'b1000, 4'b1000, 32'h5500_0000, 1, 4'b0000, 1, 8'hA3, 4'b1000);
    act (1, 4'b1000, 4'b1000, 32'h5500_0000, 1, 4'b1000, 1, 8'h55, 4'b1000);
    idle(0, 1, 4'b0000, 4'b0000, 32'h0, 1);
    want = '{8'hA3, 8'h55};
`else
    // Single requester: req1 sends 0x11, 0x22, 0x33.
    idle(0, 1, 4'b0010, 4'b0000, 32'h0000_1100, 1);
    act (1, 4'b0010, 4'b0000, 32'h0000_1100, 1, 4'b0010, 1, 8'h11, 4'b0010);
    act (1, 4'b0010, 4'b0000, 32'h0000_2200, 1, 4'b0010, 1, 8'h22, 4'b0010);
    act (1, 4'b0010, 4'b0010, 32'h0000_3300, 1, 4'b0010, 1, 8'h33, 4'b0010);
    idle(0, 1, 4'b0000, 4'b0000, 32'h0, 1);

    // Fairness: pointer now at 2, order 2,3,0,1 with one idle cycle between.
    idle(0, 1, 4'b1111, 4'b1111, 32'hD3C2_B1A0, 1);
    act (1, 4'b1111, 4'b1111, 32'hD3C2_B1A0, 1, 4'b0100, 1, 8'hC2, 4'b0100);
    idle(0, 1, 4'b1111, 4'b1111, 32'hD3C2_B1A0, 1);
    act (1, 4'b1111, 4'b1111, 32'hD3C2_B1A0, 1, 4'b1000, 1, 8'hD3, 4'b1000);
    idle(0, 1, 4'b1111, 4'b1111, 32'hD3C2_B1A0, 1);
    act (1, 4'b1111, 4'b1111, 32'hD3C2_B1A0, 1, 4'b0001, 1, 8'hA0, 4'b0001);
    idle(0, 1, 4'b1111, 4'b1111, 32'hD3C2_B1A0, 1);
    act (1, 4'b1111, 4'b1111, 32'hD3C2_B1A0, 1, 4'b0010, 1, 8'hB1, 4'b0010);

    // Truncation: req2 sends a 10-byte packet while req0 waits.
    idle(0, 1, 4'b0101, 4'b0001, 32'h0020_005A, 1);
    act (1, 4'b0101, 4'b0001, 32'h0020_005A, 1, 4'b0100, 1, 8'h20, 4'b0100);
    act (1, 4'b0101, 4'b0001, 32'h0021_005A, 1, 4'b0100, 1, 8'h21, 4'b0100);
    act (1, 4'b0101, 4'b0001, 32'h0022_005A, 1, 4'b0100, 1, 8'h22, 4'b0100);
    act (1, 4'b0101, 4'b0001, 32'h0023_005A, 1, 4'b0100, 1, 8'h23, 4'b0100);
    idle(0, 1, 4'b0101, 4'b0001, 32'h0024_005A, 1);
    act (1, 4'b0101, 4'b0001, 32'h0024_005A, 1, 4'b0001, 1, 8'h5A, 4'b0001);
    idle(0, 1, 4'b0100, 4'b0000, 32'h0024_0000, 1);
    // Continuation with backpressure 1,0,0,1.
    act (1, 4'b0100, 4'b0000, 32'h0024_0000, 1, 4'b0100, 1, 8'h24, 4'b0100);
    act (1, 4'b0100, 4'b0000, 32'h0025_0000, 0, 4'b0000, 1, 8'h25, 4'b0100);
    act (1, 4'b0100, 4'b0000, 32'h0025_0000, 0, 4'b0000, 1, 8'h25, 4'b0100);
    act (1, 4'b0100, 4'b0000, 32'h0025_0000, 1, 4'b0100, 1, 8'h25, 4'b0100);
    act (1, 4'b0100, 4'b0000, 32'h0026_0000, 1, 4'b0100, 1, 8'h26, 4'b0100);
    act (1, 4'b0100, 4'b0000, 32'h0027_0000, 1, 4'b0100, 1, 8'h27, 4'b0100);
    // Final part; enable drops mid-packet and the packet still completes.
    idle(0, 1, 4'b0100, 4'b0000, 32'h0028_0000, 1);
    act (0, 4'b0100, 4'b0000, 32'h0028_0000, 1, 4'b0100, 1, 8'h28, 4'b0100);
    act (0, 4'b0100, 4'b0100, 32'h0029_0000, 1, 4'b0100, 1, 8'h29, 4'b0100);
    idle(0, 0, 4'b1001, 4'b0001, 32'hD300_00A0, 1);
    idle(0, 0, 4'b1001, 4'b0001, 32'hD300_00A0, 1);
    // Pointer at 3: req3 wins, then reset aborts its packet.
    idle(0, 1, 4'b1001, 4'b0001, 32'hD300_00A0, 1);
    act (1, 4'b1001, 4'b0001, 32'hD300_00A0, 1, 4'b1000, 1, 8'hD3, 4'b1000);
    idle(1, 1, 4'b1001, 4'b0001, 32'hD300_00A0, 1);
    // After reset the pointer is 0: req0 beats req3.
    idle(0, 1, 4'b1001, 4'b1001, 32'hD300_00A0, 1);
    act (1, 4'b1001, 4'b1001, 32'hD300_00A0, 1, 4'b0001, 1, 8'hA0, 4'b0001);
    idle(0, 1, 4'b1001, 4'b1001, 32'hD300_00A0, 1);
    act (1, 4'b1001, 4'b1001, 32'hD300_00A0, 1, 4'b1000, 1, 8'hD3, 4'b1000);
    idle(0, 1, 4'b0000, 4'b0000, 32'h0, 1);
    want = '{8'h11, 8'h22, 8'h33, 8'hC2, 8'hD3, 8'hA0, 8'hB1,
             8'h20, 8'h21, 8'h22, 8'h23, 8'h5A, 8'h24, 8'h25, 8'h26, 8'h27,
             8'h28, 8'h29, 8'hD3, 8'hA0, 8'hD3};
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      arst_i      = vecs[i].arst;
      enable_i    = vecs[i].en;
      req_valid_i = vecs[i].vld;
      req_last_i  = vecs[i].lst;
      req_data_i  = vecs[i].data;
      out_ready_i = vecs[i].ordy;
      #1;
      n_vec++;
      if (req_ready_o !== vecs[i].rdy || out_valid_o !== vecs[i].ov ||
          out_data_o !== vecs[i].od || grant_o !== vecs[i].gnt || busy_o !== vecs[i].busy) begin
        n_bad++;
        $display("FAIL vec%0d: got rdy=%b ov=%b od=%h gnt=%b busy=%b, want rdy=%b ov=%b od=%h gnt=%b busy=%b",
                 i, req_ready_o, out_valid_o, out_data_o, grant_o, busy_o,
                 vecs[i].rdy, vecs[i].ov, vecs[i].od, vecs[i].gnt, vecs[i].busy);
      end
      if (!arst_i && out_valid_o && out_ready_i) seen.push_back(out_data_o);
    end

    n_vec++;
    if (seen.size() != want.size()) begin
      n_bad++;
      $display("FAIL stream_len: got %0d bytes, want %0d", seen.size(), want.size());
    end
    for (int i = 0; i < want.size() && i < seen.size(); i++) begin
      n_vec++;
      if (seen[i] !== want[i]) begin
        n_bad++;
        $display("FAIL stream_byte%0d: got %h, want %h", i, seen[i], want[i]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
